// File: rtl/spi_target.sv
// spi_target: byte-oriented, LSB-first SPI target with an 8-bit register bus and a level interrupt.
// Define SPI_TARGET_RXFIFO_EN for a 4-entry RX FIFO; the default build keeps a single RX byte register.
module spi_target (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_clk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       miso,
    output logic       miso_oe,
    output logic       interrupt,
    input  logic [2:0] reg_addr,
    input  logic [7:0] reg_data_in,
    output logic [7:0] reg_data_out,
    input  logic       reg_read,
    input  logic       reg_write
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_e;

    logic [2:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;
    logic [1:0] csn_sync_q;

    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_shift_q;
    logic [7:0] tx_shift_q;
    logic       miso_q;

    logic [7:0] tx_hold_q;
    logic       tx_full_q;
    logic       overrun_q;
    logic       underrun_q;
    logic [3:0] ien_q;
    logic       cpol_q;
    logic       cpha_q;
    logic       irq_q;

    logic       sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, drive_edge;
    logic       push_req, push_ok, pop, load_now;
    logic       tx_wr, stat_wr, cfg_wr;
    logic [7:0] push_data, tx_load_byte, rx_head;
    logic       rx_valid, rx_full;
    logic [3:0] pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= 2'b11;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            csn_sync_q  <= {csn_sync_q[0], cs_n};
        end
    end

    assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign drive_edge  = cpha_q ? lead_edge : trail_edge;

    // State tracks the synchronised cs_n exactly, so csn_sync_q[0] is its next value.
    assign push_req  = (state_q == ST_SHIFT) && !csn_sync_q[0] && sample_edge && (bit_cnt_q == 3'd7);
    assign push_data = {mosi_sync_q[1], rx_shift_q[7:1]};
    assign load_now  = ((state_q == ST_LOAD) && !csn_sync_q[0]) || push_req;

    assign tx_wr   = reg_write && (reg_addr == 3'd0);
    assign stat_wr = reg_write && (reg_addr == 3'd1);
    assign cfg_wr  = reg_write && (reg_addr == 3'd2);
    assign pop     = reg_read && (reg_addr == 3'd0) && rx_valid;
    assign push_ok = push_req && (!rx_full || pop);

    assign tx_load_byte = tx_full_q ? tx_hold_q : (tx_wr ? reg_data_in : 8'hFF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= 8'hFF;
            miso_q     <= 1'b1;
        end else if (csn_sync_q[0]) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            miso_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_q <= ST_LOAD;
                ST_LOAD: begin
                    state_q    <= ST_SHIFT;
                    tx_shift_q <= tx_load_byte;
                    if (!cpha_q) miso_q <= tx_load_byte[0];
                end
                ST_SHIFT: begin
                    if (sample_edge) begin
                        rx_shift_q <= push_data;
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            tx_shift_q <= tx_load_byte;
                            if (!cpha_q) miso_q <= tx_load_byte[0];
                        end
                    end else if (drive_edge) begin
                        // bit_cnt counts samples taken, so it already indexes the next bit to drive.
                        miso_q <= tx_shift_q[bit_cnt_q];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_TARGET_RXFIFO_EN
    logic [7:0] rx_mem_q [4];
    logic [1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [2:0] rx_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            if (push_ok) rx_wr_ptr_q <= rx_wr_ptr_q + 2'd1;
            if (pop)     rx_rd_ptr_q <= rx_rd_ptr_q + 2'd1;
            rx_count_q <= rx_count_q + 3'(push_ok) - 3'(pop);
        end
    end

    // NOTE: storage array has no reset; the count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) rx_mem_q[rx_wr_ptr_q] <= push_data;
    end

    assign rx_valid = (rx_count_q != 3'd0);
    assign rx_full  = (rx_count_q == 3'd4);
    assign rx_head  = rx_mem_q[rx_rd_ptr_q];
`else
    logic [7:0] rx_data_q;
    logic       rx_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (push_ok) begin
            rx_data_q  <= push_data;
            rx_valid_q <= 1'b1;
        end else if (pop) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_full  = rx_valid_q;
    assign rx_head  = rx_data_q;
`endif

    assign pending = ien_q & {overrun_q, underrun_q, ~tx_full_q, rx_valid};

    // Flag sets are written after the clears so a set wins a same-cycle collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_hold_q  <= '0;
            tx_full_q  <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            ien_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (load_now && tx_full_q) tx_full_q <= 1'b0;
            if (tx_wr) begin
                tx_hold_q <= reg_data_in;
                if (!(load_now && !tx_full_q)) tx_full_q <= 1'b1;
            end
            if (stat_wr && reg_data_in[3]) overrun_q <= 1'b0;
            if (push_req && !push_ok)      overrun_q <= 1'b1;
            if (stat_wr && reg_data_in[2]) underrun_q <= 1'b0;
            if (load_now && !tx_full_q && !tx_wr) underrun_q <= 1'b1;
            if (cfg_wr) begin
                ien_q  <= reg_data_in[7:4];
                cpol_q <= reg_data_in[1];
                cpha_q <= reg_data_in[0];
            end
            irq_q <= |pending;
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps this block free of latches.
        reg_data_out = 8'h00;
        case (reg_addr)
            3'd0:    reg_data_out = rx_valid ? rx_head : 8'h00;
            3'd1:    reg_data_out = {3'b000, rx_full, overrun_q, underrun_q, ~tx_full_q, rx_valid};
            3'd2:    reg_data_out = {ien_q, 2'b00, cpol_q, cpha_q};
            3'd3:    reg_data_out = {4'b0000, pending};
            default: reg_data_out = 8'h00;
        endcase
    end

    assign miso      = miso_q;
    assign miso_oe   = ~csn_sync_q[1];
    assign interrupt = irq_q;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: drives spi_target as an SPI initiator plus register master and checks it
// against a queue-based reference model of the RX store, TX holding register and flags.
module tb_spi_target;

`ifdef SPI_TARGET_RXFIFO_EN
    localparam int RX_DEPTH = 4;
`else
    localparam int RX_DEPTH = 1;
`endif
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_clk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       miso, miso_oe, interrupt;
    logic [2:0] reg_addr = 3'd0;
    logic [7:0] reg_data_in = 8'h00;
    logic [7:0] reg_data_out;
    logic       reg_read = 1'b0;
    logic       reg_write = 1'b0;

    spi_target dut (
        .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .miso_oe(miso_oe), .interrupt(interrupt),
        .reg_addr(reg_addr), .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
        .reg_read(reg_read), .reg_write(reg_write)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] rx_q[$];
    logic       model_full = 1'b0;
    logic [7:0] model_hold = 8'h00;
    logic       model_ovr = 1'b0;
    logic       model_und = 1'b0;
    logic [3:0] model_ien = 4'h0;
    logic [7:0] cur_tx = 8'hFF;
    logic       cur_cpol = 1'b0;
    logic       cur_cpha = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] model_status();
        logic [7:0] s;
        s    = 8'h00;
        s[4] = (rx_q.size() == RX_DEPTH);
        s[3] = model_ovr;
        s[2] = model_und;
        s[1] = !model_full;
        s[0] = (rx_q.size() != 0);
        return s;
    endfunction

    function automatic logic [3:0] model_pending();
        return model_ien & {model_ovr, model_und, !model_full, rx_q.size() != 0};
    endfunction

    task automatic model_load(output logic [7:0] b);
        if (model_full) begin
            b = model_hold;
            model_full = 1'b0;
        end else begin
            b = 8'hFF;
            model_und = 1'b1;
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
        else model_ovr = 1'b1;
    endtask

    task automatic model_reset();
        rx_q.delete();
        model_full = 1'b0;
        model_hold = 8'h00;
        model_ovr = 1'b0;
        model_und = 1'b0;
        model_ien = 4'h0;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        reg_addr = a;
        reg_data_in = d;
        reg_write = 1'b1;
        tick(1);
        reg_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, input logic do_pop, output logic [7:0] d);
        reg_addr = a;
        reg_read = do_pop;
        #1 d = reg_data_out;
        tick(1);
        reg_read = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b);
        reg_wr(3'd0, b);
        model_hold = b;
        model_full = 1'b1;
    endtask

    task automatic clear_flags(input logic [7:0] mask);
        reg_wr(3'd1, mask);
        if (mask[3]) model_ovr = 1'b0;
        if (mask[2]) model_und = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [7:0] d;
        reg_rd(3'd1, 1'b0, d);
        check(tag, d, model_status());
    endtask

    task automatic check_pop(input string tag);
        logic [7:0] d, e;
        e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        reg_rd(3'd0, 1'b1, d);
        check(tag, d, e);
    endtask

    task automatic check_irq(input string tag);
        logic [7:0] d;
        tick(1);
        check({tag, "_irq"}, {7'b0, interrupt}, {7'b0, |model_pending()});
        reg_rd(3'd3, 1'b0, d);
        check({tag, "_pend"}, d, {4'b0, model_pending()});
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic [3:0] ien);
        cur_cpol = pol;
        cur_cpha = pha;
        spi_clk = pol;
        model_ien = ien;
        reg_wr(3'd2, {ien, 2'b00, pol, pha});
        tick(4);
    endtask

    task automatic spi_begin();
        cs_n = 1'b0;
        model_load(cur_tx);
        tick(6);
    endtask

    task automatic spi_end();
        cs_n = 1'b1;
        tick(6);
    endtask

    // Shifts nbits of mo; for a whole byte also returns what the model says miso should carry.
    task automatic spi_byte(input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi, output logic [7:0] exp);
        mi = 8'h00;
        exp = cur_tx;
        if (!cur_cpha) mosi = mo[0];
        for (int i = 0; i < nbits; i++) begin
            if (!cur_cpha) begin
                mi[i] = miso;
                spi_clk = ~cur_cpol;
                tick(HALF);
                spi_clk = cur_cpol;
                if (i + 1 < nbits) mosi = mo[i+1];
                tick(HALF);
            end else begin
                mosi = mo[i];
                spi_clk = ~cur_cpol;
                tick(HALF);
                mi[i] = miso;
                spi_clk = cur_cpol;
                tick(HALF);
            end
        end
        if (nbits == 8) begin
            model_push(mo);
            model_load(cur_tx);
        end
    endtask

    task automatic do_transfer(input string tag, input logic pol, input logic pha,
                               input logic [3:0] ien, input logic [7:0] txb, input logic [7:0] mob);
        logic [7:0] mi, exp;
        set_mode(pol, pha, ien);
        tx_write(txb);
        spi_begin();
        check({tag, "_oe_hi"}, {7'b0, miso_oe}, 8'h01);
        spi_byte(mob, 8, mi, exp);
        check({tag, "_miso"}, mi, exp);
        spi_end();
        check({tag, "_oe_lo"}, {7'b0, miso_oe}, 8'h00);
        check_status({tag, "_st"});
        check_irq(tag);
        check_pop({tag, "_rx"});
        check_status({tag, "_st_pop"});
        clear_flags(8'h0C);
        check_status({tag, "_st_clr"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, mi, exp;

        tick(3);
        reset_n = 1'b1;
        tick(2);
        check("rst_miso", {7'b0, miso}, 8'h01);
        check("rst_oe", {7'b0, miso_oe}, 8'h00);
        check("rst_irq", {7'b0, interrupt}, 8'h00);
        check_status("rst_status");
        reg_rd(3'd2, 1'b0, d);
        check("rst_cfg", d, 8'h00);
        check_pop("rst_rx_empty");

        do_transfer("mode0", 1'b0, 1'b0, 4'h0, 8'hA5, 8'h3C);
        do_transfer("mode1", 1'b0, 1'b1, 4'h0, 8'h81, 8'h7E);
        do_transfer("mode2", 1'b1, 1'b0, 4'h0, 8'h81, 8'h7E);
        do_transfer("mode3", 1'b1, 1'b1, 4'h0, 8'h81, 8'h7E);

        for (int k = 0; k < 6; k++) begin
            do_transfer("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)));
        end

        // TX never written: initiator must see 8'hFF and underrun must latch.
        set_mode(1'b0, 1'b0, 4'b0100);
        spi_begin();
        spi_byte(8'($urandom_range(0, 255)), 8, mi, exp);
        check("undr_miso", mi, exp);
        spi_end();
        check_status("undr_st");
        check_irq("undr");
        clear_flags(8'h04);
        check_status("undr_clr");
        check_pop("undr_rx");

        // Five back-to-back bytes without popping.
        set_mode(1'b0, 1'b1, 4'b1000);
        clear_flags(8'h0C);
        tx_write(8'($urandom_range(0, 255)));
        spi_begin();
        for (int k = 0; k < 5; k++) begin
            spi_byte(8'($urandom_range(0, 255)), 8, mi, exp);
            check("b2b_miso", mi, exp);
        end
        spi_end();
        check_status("b2b_st");
        check_irq("b2b");
        for (int k = 0; k < 5; k++) check_pop("b2b_rx");
        check_status("b2b_st_drained");
        clear_flags(8'h0C);

        // cs_n raised after 5 bits, then a full 8'h12 transfer.
        set_mode(1'b0, 1'b0, 4'h0);
        spi_begin();
        spi_byte(8'hFF, 5, mi, exp);
        spi_end();
        check_status("abort_st");
        spi_begin();
        spi_byte(8'h12, 8, mi, exp);
        check("abort_miso", mi, exp);
        spi_end();
        check_pop("abort_rx");
        check_pop("abort_rx_empty");
        check_status("abort_st_end");

        // Reset pulsed mid-transfer with every interrupt enabled.
        set_mode(1'b0, 1'b0, 4'hF);
        tx_write(8'h5A);
        check_irq("prereset");
        spi_begin();
        spi_byte(8'h33, 3, mi, exp);
        #2 reset_n = 1'b0;
        #1;
        check("reset_irq", {7'b0, interrupt}, 8'h00);
        check("reset_oe", {7'b0, miso_oe}, 8'h00);
        check("reset_miso", {7'b0, miso}, 8'h01);
        reg_addr = 3'd2;
        #1 check("reset_cfg", reg_data_out, 8'h00);
        reg_addr = 3'd1;
        #1 check("reset_status", reg_data_out, 8'h02);
        cs_n = 1'b1;
        spi_clk = 1'b0;
        tick(3);
        reset_n = 1'b1;
        model_reset();
        tick(4);
        check_status("post_reset_st");
        check_pop("post_reset_rx");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
